// File: rtl/bus_fabric_pkg.sv
// Shared address map, slave indices and read-pipeline entry type for mem_bus_fabric.
// Region order here fixes the bit order of every packed per-slave bus.
package bus_fabric_pkg;

    localparam int NUM_MAP    = 6;
    localparam int IDX_W      = 4;
    localparam int SLV_RAM    = 0;
    localparam int SLV_MMIO   = 1;
    localparam int SLV_BULLET = 2;
    localparam int SLV_SPRITE = 3;
    localparam int SLV_HEALTH = 4;
    localparam int SLV_ARENA  = 5;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [NUM_MAP*32-1:0] MAP_BASE = {
        32'h7000_0000, 32'h6000_0000, 32'h5000_0000,
        32'h4000_0000, 32'hFFFF_0000, 32'h0000_0000
    };
    localparam logic [NUM_MAP*32-1:0] MAP_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_F000
    };

    // An all-zero entry is a write, so a flushed pipeline returns 0.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             miss;
        logic             is_read;
    } rd_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/bus_rd_pipe.sv
// Delays the {index, miss, is_read} select entry by RD_LAT cycles so the read
// mux lines up with synchronous slave RAMs; RD_LAT=0 is a straight wire.
module bus_rd_pipe
    import bus_fabric_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  rd_entry_t in_entry,
    output rd_entry_t out_entry
);

    generate
        if (RD_LAT == 0) begin : g_bypass
            assign out_entry = in_entry;
        end else begin : g_pipe
            rd_entry_t stage_reg [RD_LAT];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= in_entry;
                    for (int i = 1; i < RD_LAT; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign out_entry = stage_reg[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mem_bus_fabric.sv
// Base/mask address decode, one-hot slave enables, latency-aligned read mux and
// unmapped-access error reporting. Per-slave access counters: BUS_FABRIC_STATS_EN.
module mem_bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                         NUM_SLAVES = 6,
    parameter int                         DATA_W     = 32,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = MAP_BASE,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = MAP_MASK,
    parameter int                         RD_LAT     = 1,
    parameter logic [DATA_W-1:0]          ERR_WORD   = DATA_W'(ERR_WORD_DEFAULT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic                         cpu_wren,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic [NUM_SLAVES-1:0]        s_wen,
    output logic [NUM_SLAVES-1:0]        s_ren,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic                         err_clr,
    output logic                         err_sticky,
    output logic [15:0]                  err_count,
    output logic [NUM_SLAVES*16-1:0]     stats_out
);

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] sel;
    logic [IDX_W-1:0]      sel_idx;
    logic                  miss;
    rd_entry_t             issue_entry;
    rd_entry_t             done_entry;
    logic                  err_sticky_reg;
    logic [15:0]           err_count_reg;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
            assign hit[gi] = (cpu_addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32];
        end
    endgenerate

    // Scan from the top so the lowest-indexed overlapping region wins.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = '0;
                sel[i]  = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign miss    = ~|hit;
    assign s_wen   = {NUM_SLAVES{cpu_wren}} & sel;
    assign s_ren   = {NUM_SLAVES{~cpu_wren}} & sel;
    assign s_wdata = cpu_wdata;

    assign issue_entry = '{idx: sel_idx, miss: miss, is_read: ~cpu_wren};

    bus_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_entry  (issue_entry),
        .out_entry (done_entry)
    );

    always_comb begin
        cpu_rdata = '0;
        if (done_entry.is_read) begin
            if (done_entry.miss) begin
                cpu_rdata = ERR_WORD;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (done_entry.idx == IDX_W'(i)) begin
                        cpu_rdata = s_rdata[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // A clear still records a miss from the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
        end else if (err_clr) begin
            err_sticky_reg <= miss;
            err_count_reg  <= {15'd0, miss};
        end else if (miss) begin
            err_sticky_reg <= 1'b1;
            err_count_reg  <= sat_inc(err_count_reg);
        end
    end

    assign err_sticky = err_sticky_reg;
    assign err_count  = err_count_reg;

`ifdef BUS_FABRIC_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_stats
            logic [15:0] count_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (err_clr) begin
                    count_reg <= {15'd0, sel[gi]};
                end else if (sel[gi]) begin
                    count_reg <= sat_inc(count_reg);
                end
            end

            assign stats_out[gi*16 +: 16] = count_reg;
        end
    endgenerate
`else
    assign stats_out = '0;
`endif

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Self-checking bench for mem_bus_fabric (RD_LAT=1): directed map scenarios plus
// randomized traffic compared every cycle against an address-range reference model.
module tb_mem_bus_fabric;
    import bus_fabric_pkg::*;

    localparam int NS = 6;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       cpu_addr = '0;
    logic [DW-1:0]     cpu_wdata = '0;
    logic              cpu_wren = 1'b0;
    logic [DW-1:0]     cpu_rdata;
    logic [NS-1:0]     s_wen;
    logic [NS-1:0]     s_ren;
    logic [DW-1:0]     s_wdata;
    logic [NS*DW-1:0]  s_rdata = '0;
    logic              err_clr = 1'b0;
    logic              err_sticky;
    logic [15:0]       err_count;
    logic [NS*16-1:0]  stats_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state: what the previous access was and the error/stat tallies.
    bit          m_prev_read = 1'b0;
    bit          m_prev_miss = 1'b0;
    int          m_prev_reg  = 0;
    bit          m_sticky    = 1'b0;
    int          m_count     = 0;
    int          m_stats [NS];

    mem_bus_fabric dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wren   (cpu_wren),
        .cpu_rdata  (cpu_rdata),
        .s_wen      (s_wen),
        .s_ren      (s_ren),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .stats_out  (stats_out)
    );

    always #5 clock = ~clock;

    // Region by address range; -1 means unmapped.
    function automatic int region_of(input logic [31:0] a);
        if (a < 32'h0000_1000)              return SLV_RAM;
        if (a[31:8] == 24'hFFFF00)          return SLV_MMIO;
        if (a[31:16] == 16'h4000)           return SLV_BULLET;
        if (a[31:16] == 16'h5000)           return SLV_SPRITE;
        if (a[31:16] == 16'h6000)           return SLV_HEALTH;
        if (a[31:16] == 16'h7000)           return SLV_ARENA;
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_prev_read <= 1'b0;
            m_prev_miss <= 1'b0;
            m_prev_reg  <= 0;
            m_sticky    <= 1'b0;
            m_count     <= 0;
            for (int i = 0; i < NS; i++) m_stats[i] <= 0;
        end else begin
            m_prev_read <= !cpu_wren;
            m_prev_miss <= (region_of(cpu_addr) < 0);
            m_prev_reg  <= region_of(cpu_addr);
            if (err_clr) begin
                m_sticky <= (region_of(cpu_addr) < 0);
                m_count  <= (region_of(cpu_addr) < 0) ? 1 : 0;
            end else if (region_of(cpu_addr) < 0) begin
                m_sticky <= 1'b1;
                m_count  <= (m_count >= 65535) ? 65535 : m_count + 1;
            end
            for (int i = 0; i < NS; i++) begin
                if (err_clr)
                    m_stats[i] <= (region_of(cpu_addr) == i) ? 1 : 0;
                else if (region_of(cpu_addr) == i && m_stats[i] < 65535)
                    m_stats[i] <= m_stats[i] + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            automatic int            r = region_of(cpu_addr);
            automatic logic [NS-1:0] exp_sel = (r >= 0) ? NS'(1 << r) : '0;
            automatic logic [DW-1:0] exp_rd;
            automatic logic [NS*16-1:0] exp_st = '0;
            if (!m_prev_read)      exp_rd = '0;
            else if (m_prev_miss)  exp_rd = 32'hDEAD_BEEF;
            else                   exp_rd = s_rdata[m_prev_reg*DW +: DW];
`ifdef BUS_FABRIC_STATS_EN
            for (int i = 0; i < NS; i++) exp_st[i*16 +: 16] = 16'(m_stats[i]);
`endif
            check("s_wen",      128'(s_wen),      128'(cpu_wren ? exp_sel : '0));
            check("s_ren",      128'(s_ren),      128'(cpu_wren ? '0 : exp_sel));
            check("s_wdata",    128'(s_wdata),    128'(cpu_wdata));
            check("cpu_rdata",  128'(cpu_rdata),  128'(exp_rd));
            check("err_sticky", 128'(err_sticky), 128'(m_sticky));
            check("err_count",  128'(err_count),  128'(m_count));
            check("stats_out",  128'(stats_out),  128'(exp_st));
        end
    end

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic c, input logic r);
        @(posedge clock);
        #1;
        cpu_addr  = a;
        cpu_wren  = w;
        cpu_wdata = d;
        err_clr   = c;
        reset     = r;
    endtask

    task automatic step(input string label, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic c, input logic r);
        drive(a, w, d, c, r);
        $display("txn %-10s addr=%h wren=%0d wdata=%h clr=%0d rst=%0d", label, a, w, d, c, r);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);

        step("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Write to Bullet: only its write enable fires; reset state still visible.
        step("wr_bullet", 32'h4000_0008, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
        @(negedge clock);
        check("d_wen_bullet", 128'(s_wen), 128'(6'b000100));
        check("d_ren_none",   128'(s_ren), 128'(6'b000000));
        check("d_rst_rdata",  128'(cpu_rdata), 128'(32'h0));
        check("d_rst_count",  128'(err_count), 128'(16'h0));

        step("rd_bullet", 32'h4000_0008, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_ren_bullet", 128'(s_ren), 128'(6'b000100));
        check("d_rd_after_wr", 128'(cpu_rdata), 128'(32'h0));

        step("rd_ram", 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_bullet_data", 128'(cpu_rdata), 128'(32'hA000_0002));

        step("rd_mmio", 32'hFFFF_0004, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_ram_data", 128'(cpu_rdata), 128'(32'hA000_0000));

        step("rd_arena", 32'h7000_03FC, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_mmio_data", 128'(cpu_rdata), 128'(32'hA000_0001));

        step("rd_unmap", 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_arena_data", 128'(cpu_rdata), 128'(32'hA000_0005));
        check("d_unmap_wen",  128'(s_wen), 128'(6'b0));
        check("d_unmap_ren",  128'(s_ren), 128'(6'b0));

        step("rd_ram", 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_err_word",   128'(cpu_rdata), 128'(32'hDEAD_BEEF));
        check("d_err_sticky", 128'(err_sticky), 128'(1'b1));
        check("d_err_count1", 128'(err_count), 128'(16'd1));

        // Saturation: 0x10002 consecutive misses after a fresh reset.
        step("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        $display("txn burst      65538 unmapped accesses to 0x8000_0000");
        for (int i = 0; i < 32'h10002; i++) drive(32'h8000_0000, 1'(i & 1), 32'(i), 1'b0, 1'b0);
        step("rd_ram", 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_sat_count", 128'(err_count), 128'(16'hFFFF));
        step("clr_miss", 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
        step("rd_ram", 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_clr_miss_count",  128'(err_count), 128'(16'd1));
        check("d_clr_miss_sticky", 128'(err_sticky), 128'(1'b1));

        // Reset with a Sprite read in flight flushes it.
        step("rd_sprite", 32'h5000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        step("reset", 32'h5000_0000, 1'b0, 32'h0, 1'b0, 1'b1);
        step("rd_ram", 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("d_flush_rdata", 128'(cpu_rdata), 128'(32'h0));
        check("d_flush_count", 128'(err_count), 128'(16'h0));

        for (int i = 0; i < 5; i++) step("sprite", 32'h5000_0010 + 32'(4*i), 1'(i & 1), 32'(i), 1'b0, 1'b0);
        step("rd_unmap", 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
`ifdef BUS_FABRIC_STATS_EN
        check("d_stats_sprite", 128'(stats_out[SLV_SPRITE*16 +: 16]), 128'(16'd5));
        check("d_stats_ram",    128'(stats_out[SLV_RAM*16 +: 16]),    128'(16'd1));
`else
        check("d_stats_off", 128'(stats_out), 128'(0));
`endif

        // Randomized traffic, checked every cycle by the compare process.
        $display("txn random     3000 randomized accesses");
        for (int n = 0; n < 3000; n++) begin
            automatic int          k = $urandom_range(0, 6);
            automatic logic [31:0] a;
            case (k)
                0:       a = {20'h0, 12'($urandom)};
                1:       a = {24'hFFFF00, 8'($urandom)};
                2, 3, 4, 5: a = {16'h4000 + 16'((k - 2) * 16'h1000), 16'($urandom)};
                default: a = $urandom;
            endcase
            drive(a, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 255) == 0));
            for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
